branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised branch prediction unit for the 5-stage RV32I pipeline. It replaces the "fetch pc+4, flush on taken in EX" scheme.
- Fetch stage: looks up the current PC in a direct-mapped branch target buffer (BTB) and returns a predicted next PC.
- Execute stage: receives the resolved branch/jump outcome, trains the BTB and saturating counters, and flags a mispredict with the redirect PC.
- Optional performance counters track branch count and mispredict count.

Parameters:
XLEN, 32, datapath/PC width.
ENTRIES, 64, BTB entries; power of 2, min 4.
TAG_W, 10, tag bits stored per entry, taken from PC above the index bits.
CTR_W, 2, saturating counter width, min 1.
PERF_EN, 1, 1 = build performance counters; 0 = perf outputs tied to 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_f  in  XLEN  fetch PC
pred_taken  out  1  prediction for pc_f: 1 = redirect fetch
pred_target  out  XLEN  predicted next PC
upd_en  in  1  EX holds a valid branch/jal/jalr this cycle
upd_is_jump  in  1  1 = jal/jalr (unconditional)
upd_pc  in  XLEN  PC of the resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target (alu result)
upd_pred_taken  in  1  prediction carried down the pipe for this instruction
upd_pred_target  in  XLEN  predicted target carried down the pipe
mispredict  out  1  EX redirect required; flush IF/ID and ID/EX
redirect_pc  out  XLEN  correct next PC when mispredict=1
bp_flush  in  1  invalidate the whole BTB (fence.i / debug)
perf_branches  out  32  resolved control-flow instructions
perf_mispred  out  32  mispredicts

Behaviour:
Addressing:
- IDX_W = log2(ENTRIES).
- idx = pc[IDX_W+1:2].
- tag = pc[IDX_W+1+TAG_W : IDX_W+2]. Bits above the tag are ignored, so aliasing is allowed.

Entry contents: valid, tag, target[XLEN-1:0], is_jump, ctr[CTR_W-1:0].

Lookup (combinational, 0 latency):
- hit = valid[idx] && tag match.
- pred_taken = hit && (is_jump || ctr MSB).
- pred_target = pred_taken ? entry.target : pc_f+4 (mod 2^XLEN).

Update (at the clk edge when upd_en=1):
- Hit, conditional branch: ctr +1 if taken, -1 if not taken. Saturate at 0 and at 2^CTR_W-1; no wrap.
- Hit and taken: target <= upd_target; is_jump <= upd_is_jump.
- Miss and taken: allocate (overwrite any existing entry). valid=1, tag, target, is_jump set; ctr = weakly taken (MSB=1, other bits 0; e.g. 2'b10). A jump sets ctr = max.
- Miss and not taken: no allocation, no state change.

Mispredict (combinational on upd_* inputs):
- mispredict = upd_en && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- When mispredict=0, redirect_pc is don't-care but must be driven with this same formula.

Simultaneous events:
- Lookup and update to the same idx in one cycle: lookup sees pre-update contents; the write is visible from the next cycle.
- bp_flush with upd_en: flush wins; all valid bits are 0 after the edge and the update is discarded. Perf counters still count the update.
- bp_flush does not change ctr/target storage, only valid bits.

Perf counters (PERF_EN=1):
- perf_branches +1 per upd_en cycle.
- perf_mispred +1 per mispredict cycle.
- Both are 32-bit and wrap modulo 2^32.

Reset (asynchronous, rst_n=0, including mid-operation):
- All valid bits 0.
- Perf counters 0.
- Outputs resolve to pred_taken=0, pred_target=pc_f+4; mispredict is purely a function of inputs.
- Target/ctr arrays need no reset.
- First edge after deassert behaves as normal operation.

Decomposition:
Package bp_pkg holds:
- the btb_entry_t struct (valid, tag, target, is_jump, ctr);
- the CTR_WEAK_T / CTR_MAX constants and the index/tag extraction functions.

Sub-module sat_counter (parametrised CTR_W): combinational next-value with inc/dec and saturation. It is instantiated once, on the update path.

Test Plan:
1. After reset, lookup pc_f=0x100 -> pred_taken=0, pred_target=0x104; perf outputs 0.
2. Update pc=0x100 taken, target=0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x40; ctr=2'b10.
3. Saturation (same entry): 3 taken updates -> ctr=2'b11. Then 1 not-taken -> ctr=2'b10, still predicted taken. Second not-taken -> ctr=2'b01, pred_taken=0. Further not-takens hold ctr at 2'b00.
4. Jal update pc=0x200, target=0x300, taken -> allocated with is_jump=1. Subsequent lookup is taken regardless of any conditional-style training. Target change to 0x380 with upd_pred_target=0x300 -> mispredict=1, redirect_pc=0x380, entry target updated.
5. Aliasing and flush: with ENTRIES=64, 0x100 and 0x200 share idx 0 but differ in tag. Update 0x200 taken -> lookup 0x100 misses. Then bp_flush together with upd_en -> all lookups miss next cycle and perf_branches still increments.
6. Reset mid-run: rst_n=0 asynchronously while entries are valid -> pred_taken=0 immediately. After release, the previously trained PC misses and the perf counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the branch predictor.
//   btb_entry_t  : one BTB entry (valid, tag, target, is_jump, ctr)
//   CTR_WEAK_T   : counter value written when a conditional branch is allocated
//   CTR_MAX      : counter value written when a jump is allocated
//   bp_idx()     : BTB index = pc[idx_w+1:2]
//   bp_tag()     : BTB tag   = pc[idx_w+1+tag_w:idx_w+2]
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = 10;
    localparam int BP_CTR_W = 2;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        logic                is_jump;
        logic [BP_CTR_W-1:0] ctr;
    } btb_entry_t;

    // Weakly taken: MSB set, all other bits clear.
    localparam logic [BP_CTR_W-1:0] CTR_WEAK_T = {1'b1, {(BP_CTR_W-1){1'b0}}};
    localparam logic [BP_CTR_W-1:0] CTR_MAX    = '1;

    function automatic int unsigned bp_idx(input logic [BP_XLEN-1:0] pc,
                                           input int unsigned        idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic int unsigned bp_tag(input logic [BP_XLEN-1:0] pc,
                                           input int unsigned        idx_w,
                                           input int unsigned        tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Bundle between the pipeline (master) and the branch predictor (slave).
//   Fetch side   : pc_f -> pred_taken, pred_target
//   Execute side : upd_* -> mispredict, redirect_pc
//   Control      : bp_flush (invalidate whole BTB)
//   Perf         : perf_branches, perf_mispred
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int XLEN = bp_pkg::BP_XLEN
);
    logic [XLEN-1:0] pc_f;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            upd_en;
    logic            upd_is_jump;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    logic            bp_flush;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispred;

    modport master (
        output pc_f, upd_en, upd_is_jump, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, bp_flush,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispred
    );

    modport slave (
        input  pc_f, upd_en, upd_is_jump, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, bp_flush,
        output pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Combinational next value of a CTR_W-bit saturating counter.
//   i_ctr : current value
//   i_inc : step up (holds at all-ones)
//   i_dec : step down (holds at zero)
//   o_ctr : next value; unchanged if neither or both steps are requested
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CTR_W-1:0] o_ctr
);
    localparam logic [CTR_W-1:0] MAX = '1;

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc && !i_dec && (i_ctr != MAX)) begin
            o_ctr = i_ctr + CTR_W'(1);
        end else if (i_dec && !i_inc && (i_ctr != '0)) begin
            o_ctr = i_ctr - CTR_W'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with per-entry saturating counters for the RV32I pipeline.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears valid bits and perf counters)
//   bus   : branch_predictor_if.slave
//     fetch   : pc_f -> pred_taken / pred_target (combinational lookup)
//     execute : upd_* -> mispredict / redirect_pc (combinational), BTB trained
//               at the clock edge when upd_en=1
//     control : bp_flush clears every valid bit, discarding a same-cycle update
//     perf    : perf_branches / perf_mispred (tied to 0 when PERF_EN=0)
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = BP_TAG_W,
    parameter int CTR_W   = BP_CTR_W,
    parameter int PERF_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    // The entry struct is sized from bp_pkg, so the field widths must agree.
    if (XLEN != BP_XLEN || TAG_W != BP_TAG_W || CTR_W != BP_CTR_W) begin : g_bad_width
        $error("branch_predictor: XLEN/TAG_W/CTR_W must match bp_pkg widths");
    end
    if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of 2 and >= 4");
    end

    btb_entry_t r_btb [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;

    assign w_f_idx   = IDX_W'(bp_idx(bus.pc_f, IDX_W));
    assign w_f_tag   = TAG_W'(bp_tag(bus.pc_f, IDX_W, TAG_W));
    assign w_f_hit   = r_btb[w_f_idx].valid && (r_btb[w_f_idx].tag == w_f_tag);
    assign w_f_taken = w_f_hit && (r_btb[w_f_idx].is_jump || r_btb[w_f_idx].ctr[CTR_W-1]);

    assign bus.pred_taken  = w_f_taken;
    assign bus.pred_target = w_f_taken ? r_btb[w_f_idx].target : (bus.pc_f + XLEN'(4));

    // ---------------- resolve ----------------
    logic w_mispredict;

    assign w_mispredict = bus.upd_en &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

    assign bus.mispredict  = w_mispredict;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + XLEN'(4));

    // ---------------- training ----------------
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [CTR_W-1:0] w_u_ctr_nxt;

    assign w_u_idx = IDX_W'(bp_idx(bus.upd_pc, IDX_W));
    assign w_u_tag = TAG_W'(bp_tag(bus.upd_pc, IDX_W, TAG_W));
    assign w_u_hit = r_btb[w_u_idx].valid && (r_btb[w_u_idx].tag == w_u_tag);

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .i_ctr (r_btb[w_u_idx].ctr),
        .i_inc (bus.upd_taken),
        .i_dec (!bus.upd_taken),
        .o_ctr (w_u_ctr_nxt)
    );

    // Reset and flush touch only the valid bits; tag/target/ctr keep their
    // contents. Lookup reads this array combinationally, so a same-cycle
    // lookup sees the pre-update entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (bus.bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (bus.upd_en) begin
            if (w_u_hit) begin
                if (!bus.upd_is_jump) begin
                    r_btb[w_u_idx].ctr <= w_u_ctr_nxt;
                end
                if (bus.upd_taken) begin
                    r_btb[w_u_idx].target  <= bus.upd_target;
                    r_btb[w_u_idx].is_jump <= bus.upd_is_jump;
                end
            end else if (bus.upd_taken) begin
                // Allocation overwrites whatever lives at this index.
                r_btb[w_u_idx].valid   <= 1'b1;
                r_btb[w_u_idx].tag     <= w_u_tag;
                r_btb[w_u_idx].target  <= bus.upd_target;
                r_btb[w_u_idx].is_jump <= bus.upd_is_jump;
                r_btb[w_u_idx].ctr     <= bus.upd_is_jump ? CTR_MAX : CTR_WEAK_T;
            end
        end
    end

    // ---------------- performance counters ----------------
    if (PERF_EN != 0) begin : g_perf
        logic [31:0] r_branches;
        logic [31:0] r_mispred;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_branches <= '0;
                r_mispred  <= '0;
            end else begin
                if (bus.upd_en) begin
                    r_branches <= r_branches + 32'd1;
                end
                if (w_mispredict) begin
                    r_mispred <= r_mispred + 32'd1;
                end
            end
        end

        assign bus.perf_branches = r_branches;
        assign bus.perf_mispred  = r_mispred;
    end else begin : g_no_perf
        assign bus.perf_branches = '0;
        assign bus.perf_mispred  = '0;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor (ENTRIES=64, TAG_W=10, CTR_W=2).
// Expected values are worked out by hand from the predictor's behaviour.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    branch_predictor_if #(.XLEN(32)) bif ();

    branch_predictor #(
        .XLEN    (32),
        .ENTRIES (64),
        .TAG_W   (10),
        .CTR_W   (2),
        .PERF_EN (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        bif.pc_f = pc;
        #1;
        chk({tag, ".taken"},  32'(bif.pred_taken), 32'(exp_taken));
        chk({tag, ".target"}, bif.pred_target, exp_tgt);
    endtask

    task automatic perf(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mp);
        chk({tag, ".branches"}, bif.perf_branches, exp_br);
        chk({tag, ".mispred"},  bif.perf_mispred,  exp_mp);
    endtask

    // Drive one resolved instruction across a clock edge, checking the
    // combinational redirect before the edge.
    task automatic upd(input string tag, input logic [31:0] pc, input logic jmp,
                       input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt,
                       input logic exp_mp, input logic [31:0] exp_rd);
        bif.upd_en          = 1'b1;
        bif.upd_pc          = pc;
        bif.upd_is_jump     = jmp;
        bif.upd_taken       = taken;
        bif.upd_target      = tgt;
        bif.upd_pred_taken  = ptaken;
        bif.upd_pred_target = ptgt;
        #1;
        chk({tag, ".mispredict"},  32'(bif.mispredict), 32'(exp_mp));
        chk({tag, ".redirect_pc"}, bif.redirect_pc, exp_rd);
        tick();
        bif.upd_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bif.pc_f            = '0;
        bif.upd_en          = 1'b0;
        bif.upd_is_jump     = 1'b0;
        bif.upd_pc          = '0;
        bif.upd_taken       = 1'b0;
        bif.upd_target      = '0;
        bif.upd_pred_taken  = 1'b0;
        bif.upd_pred_target = '0;
        bif.bp_flush        = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Reset state
        look("rst_look", 32'h100, 1'b0, 32'h104);
        perf("rst_perf", 32'd0, 32'd0);
        look("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // A would-be mispredict with upd_en low must not flag.
        bif.upd_taken = 1'b1;
        bif.upd_target = 32'h40;
        bif.upd_pred_taken = 1'b0;
        #1;
        chk("no_en.mispredict", 32'(bif.mispredict), 32'd0);
        bif.upd_taken = 1'b0;

        // Allocate 0x100 -> 0x40 (ctr weakly taken)
        upd("alloc100", 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40);
        look("alloc100_look", 32'h100, 1'b1, 32'h40);
        perf("alloc100_perf", 32'd1, 32'd1);

        // Saturation: 10 -> 11 -> 11 -> 11
        upd("t1", 32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
        upd("t2", 32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
        upd("t3", 32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
        // 11 -> 10: still taken
        upd("nt1", 32'h100, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h104);
        look("nt1_look", 32'h100, 1'b1, 32'h40);
        // 10 -> 01: not taken
        upd("nt2", 32'h100, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h104);
        look("nt2_look", 32'h100, 1'b0, 32'h104);
        // 01 -> 00 -> 00
        upd("nt3", 32'h100, 1'b0, 1'b0, 32'h40, 1'b0, 32'h104, 1'b0, 32'h104);
        upd("nt4", 32'h100, 1'b0, 1'b0, 32'h40, 1'b0, 32'h104, 1'b0, 32'h104);
        // 00 -> 01: still not taken (a wrapped counter would read taken)
        upd("t4", 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40);
        look("t4_look", 32'h100, 1'b0, 32'h104);
        perf("sat_perf", 32'd9, 32'd4);

        // Jal at 0x200 aliases idx 0, evicting 0x100
        upd("jal", 32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
        look("jal_look", 32'h200, 1'b1, 32'h300);
        look("alias_look", 32'h100, 1'b0, 32'h104);
        // Conditional-style not-taken training leaves the jump predicted taken
        upd("jnt1", 32'h200, 1'b0, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h204);
        upd("jnt2", 32'h200, 1'b0, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h204);
        look("jnt_look", 32'h200, 1'b1, 32'h300);
        // Target change
        upd("jtgt", 32'h200, 1'b1, 1'b1, 32'h380, 1'b1, 32'h300, 1'b1, 32'h380);
        look("jtgt_look", 32'h200, 1'b1, 32'h380);
        upd("jok", 32'h200, 1'b1, 1'b1, 32'h380, 1'b1, 32'h380, 1'b0, 32'h380);
        perf("jal_perf", 32'd14, 32'd8);

        // Second entry at idx 1
        upd("alloc104", 32'h104, 1'b0, 1'b1, 32'h500, 1'b0, 32'h108, 1'b1, 32'h500);
        look("alloc104_look", 32'h104, 1'b1, 32'h500);
        // Miss and not taken: no allocation
        upd("miss_nt", 32'h10C, 1'b0, 1'b0, 32'h700, 1'b0, 32'h110, 1'b0, 32'h110);
        look("miss_nt_look", 32'h10C, 1'b0, 32'h110);

        // Flush together with an update: flush wins, perf still counts
        bif.bp_flush = 1'b1;
        upd("flush", 32'h108, 1'b0, 1'b1, 32'h600, 1'b0, 32'h10C, 1'b1, 32'h600);
        bif.bp_flush = 1'b0;
        look("flush_200", 32'h200, 1'b0, 32'h204);
        look("flush_104", 32'h104, 1'b0, 32'h108);
        look("flush_108", 32'h108, 1'b0, 32'h10C);
        perf("flush_perf", 32'd17, 32'd10);

        // Asynchronous reset mid-run
        upd("retrain", 32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
        look("retrain_look", 32'h200, 1'b1, 32'h300);
        rst_n = 1'b0;
        look("in_rst_look", 32'h200, 1'b0, 32'h204);
        perf("in_rst_perf", 32'd0, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        look("post_rst_look", 32'h200, 1'b0, 32'h204);
        perf("post_rst_perf", 32'd0, 32'd0);
        upd("post_rst_upd", 32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
        look("post_rst_upd_look", 32'h200, 1'b1, 32'h300);
        perf("post_rst_upd_perf", 32'd1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
